// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Purpose: shares one single-ported unified memory between the instruction
// fetch port and the data (load/store) port of the pipelined core. One
// transaction at a time goes to a variable-latency req/ack memory.
//
// Arbitration rules:
//   - Data requests win.
//   - A fairness counter forces an instruction grant after IFAIR
//     consecutive data grants that overtook a waiting instruction request.
//   - A busy-cycle counter aborts an access the memory never acknowledges.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   i_req/i_addr        instruction read request (held until i_ready)
//   i_ready/i_rdata     one-cycle completion pulse and read data
//   d_req/d_we/d_addr/d_wdata
//                       data request (held until d_ready); d_we=1 is a store
//   d_ready/d_rdata     one-cycle completion pulse and load data
//                       (d_rdata is 0 after a store)
//   m_req/m_we/m_addr/m_wdata
//                       memory request, held stable until m_ack or timeout
//   m_ack/m_rdata       memory completion; m_rdata is valid with m_ack
//   err                 pulses with the ready pulse of a timed-out access
//
// All outputs are registered.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int IFAIR   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ready,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ready,
    output logic [DW-1:0] d_rdata,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic          m_ack,
    input  logic [DW-1:0] m_rdata,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam int FAIR_W = (IFAIR < 1) ? 1 : $clog2(IFAIR + 1);
    localparam int TCNT_W = $clog2(TIMEOUT);
    localparam logic [FAIR_W-1:0] FAIR_MAX = FAIR_W'(IFAIR);
    localparam logic [TCNT_W-1:0] T_LAST   = TCNT_W'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [FAIR_W-1:0]   fair_cnt_q, fair_cnt_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic                m_req_q, m_req_d;
    logic                m_we_q, m_we_d;
    logic [AW-1:0]       m_addr_q, m_addr_d;
    logic [DW-1:0]       m_wdata_q, m_wdata_d;
    logic                i_ready_q, i_ready_d;
    logic                d_ready_q, d_ready_d;
    logic [DW-1:0]       i_rdata_q, i_rdata_d;
    logic [DW-1:0]       d_rdata_q, d_rdata_d;
    logic                err_q, err_d;

    always_comb begin
        state_d    = state_q;
        fair_cnt_d = fair_cnt_q;
        tcnt_d     = tcnt_q;
        m_req_d    = m_req_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        i_ready_d  = 1'b0;
        d_ready_d  = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (d_req && !(i_req && fair_cnt_q == FAIR_MAX)) begin
                    state_d   = BUSY_D;
                    m_req_d   = 1'b1;
                    m_we_d    = d_we;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                    tcnt_d    = '0;
                    // The grant condition already excludes fair_cnt == IFAIR
                    // while i_req is high, so the increment saturates there.
                    fair_cnt_d = i_req ? fair_cnt_q + 1'b1 : '0;
                end else if (i_req) begin
                    state_d    = BUSY_I;
                    m_req_d    = 1'b1;
                    m_we_d     = 1'b0;
                    m_addr_d   = i_addr;
                    m_wdata_d  = '0;
                    tcnt_d     = '0;
                    fair_cnt_d = '0;
                end
            end

            BUSY_I, BUSY_D: begin
                if (m_ack) begin
                    // An ack in the final allowed cycle still wins over the timeout.
                    state_d = IDLE;
                    m_req_d = 1'b0;
                    if (state_q == BUSY_I) begin
                        i_ready_d = 1'b1;
                        i_rdata_d = m_rdata;
                    end else begin
                        d_ready_d = 1'b1;
                        d_rdata_d = m_we_q ? '0 : m_rdata;
                    end
                end else if (tcnt_q == T_LAST) begin
                    state_d = IDLE;
                    m_req_d = 1'b0;
                    err_d   = 1'b1;
                    if (state_q == BUSY_I) begin
                        i_ready_d = 1'b1;
                        i_rdata_d = '0;
                    end else begin
                        d_ready_d = 1'b1;
                        d_rdata_d = '0;
                    end
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            fair_cnt_q <= '0;
            tcnt_q     <= '0;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            i_ready_q  <= 1'b0;
            d_ready_q  <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fair_cnt_q <= fair_cnt_d;
            tcnt_q     <= tcnt_d;
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            i_ready_q  <= i_ready_d;
            d_ready_q  <= d_ready_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
            err_q      <= err_d;
        end
    end

    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign i_ready = i_ready_q;
    assign i_rdata = i_rdata_q;
    assign d_ready = d_ready_q;
    assign d_rdata = d_rdata_q;
    assign err     = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: single-port transactions from a vector
// table, then hand-written sequences for priority, fairness, spurious ack
// and reset in the middle of an access.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ack = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(.AW(32), .DW(32), .IFAIR(4), .TIMEOUT(16)) dut (
        .clk(clk), .reset(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata), .err(err)
    );

    always #5 clk = ~clk;

    // Memory model: acks in the mem_delay-th cycle that m_req is high
    // (mem_delay == 0 means never). spurious_ack drives m_ack while idle.
    int          mem_delay = 1;
    int          mem_cnt = 0;
    logic [31:0] mem_rdata = '0;
    logic        spurious_ack = 1'b0;

    always @(posedge clk) begin
        #1;
        if (m_req) begin
            mem_cnt = mem_cnt + 1;
            m_ack   = (mem_delay != 0) && (mem_cnt == mem_delay);
            m_rdata = m_ack ? mem_rdata : 32'hDEAD_DEAD;
        end else begin
            mem_cnt = 0;
            m_ack   = spurious_ack;
            m_rdata = 32'hBEEF_0000;
        end
    end

    typedef struct {
        string       name;
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] mrdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_mreq;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Runs one transaction on a single port and checks the result.
    task automatic run_txn(input vec_t v);
        int          cycles;
        int          mreq_cyc;
        int          unstable;
        logic        got;
        logic        other_seen;
        logic        got_err;
        logic [31:0] got_rdata;
        cycles = 0; mreq_cyc = 0; unstable = 0;
        got = 1'b0; other_seen = 1'b0; got_err = 1'b0; got_rdata = '0;
        mem_delay = v.delay;
        mem_rdata = v.mrdata;
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
        end
        while (!got && cycles < 60) begin
            @(posedge clk); #1;
            cycles++;
            if (m_req) begin
                mreq_cyc++;
                if (m_addr !== v.addr || m_we !== (v.is_d & v.we) ||
                    (v.is_d && m_wdata !== v.wdata))
                    unstable++;
            end
            if ((v.is_d ? i_ready : d_ready) === 1'b1) other_seen = 1'b1;
            if ((v.is_d ? d_ready : i_ready) === 1'b1) begin
                got       = 1'b1;
                got_err   = err;
                got_rdata = v.is_d ? d_rdata : i_rdata;
            end
        end
        // Drop the request inside the ready cycle so it is not re-arbitrated.
        d_req = 1'b0; i_req = 1'b0; d_we = 1'b0;
        check({v.name, " ready_seen"}, 32'(got), 32'd1);
        check({v.name, " other_ready"}, 32'(other_seen), 32'd0);
        check({v.name, " rdata"}, got_rdata, v.exp_rdata);
        check({v.name, " err"}, 32'(got_err), 32'(v.exp_err));
        check({v.name, " m_req_cycles"}, 32'(mreq_cyc), 32'(v.exp_mreq));
        check({v.name, " m_bus_stable"}, 32'(unstable), 32'd0);
        @(posedge clk); #1;
        check({v.name, " idle_after"}, {29'd0, m_req, i_ready | d_ready, err}, 32'd0);
        check({v.name, " rdata_hold"}, v.is_d ? d_rdata : i_rdata, v.exp_rdata);
        $display("[TB] txn %-12s port=%s rdata=0x%08h err=%0b m_req_cycles=%0d",
                 v.name, v.is_d ? "D" : "I", got_rdata, got_err, mreq_cyc);
    endtask

    function automatic vec_t mk(input string name, input logic is_d, input logic we,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input int delay, input logic [31:0] mrdata,
                                input logic [31:0] exp_rdata, input logic exp_err,
                                input int exp_mreq);
        vec_t v;
        v.name = name; v.is_d = is_d; v.we = we; v.addr = addr; v.wdata = wdata;
        v.delay = delay; v.mrdata = mrdata; v.exp_rdata = exp_rdata;
        v.exp_err = exp_err; v.exp_mreq = exp_mreq;
        return v;
    endfunction

    vec_t vecs[7];

    initial begin
        int   cd;
        int   ci;
        int   nev;
        logic ev[6];
        logic exp_ev[6];
        logic stray;
        vec_t v;

        vecs[0] = mk("load",       1, 0, 32'h40,  32'h0,         3,  32'h1234_5678, 32'h1234_5678, 0, 3);
        vecs[1] = mk("store",      1, 1, 32'h80,  32'hCAFE_BABE, 2,  32'h5555_AAAA, 32'h0,         0, 2);
        vecs[2] = mk("ifetch",     0, 0, 32'h100, 32'h0,         1,  32'h2402_0001, 32'h2402_0001, 0, 1);
        vecs[3] = mk("load_slow",  1, 0, 32'h3FC, 32'h0,         15, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 0, 15);
        vecs[4] = mk("ack_last",   0, 0, 32'h104, 32'h0,         16, 32'h0BAD_F00D, 32'h0BAD_F00D, 0, 16);
        vecs[5] = mk("timeout",    0, 0, 32'h200, 32'h0,         0,  32'h1111_1111, 32'h0,         1, 16);
        vecs[6] = mk("d_timeout",  1, 0, 32'h84,  32'h0,         0,  32'h7777_7777, 32'h0,         1, 16);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs", {28'd0, m_req, m_we, i_ready | d_ready, err}, 32'd0);
        check("reset m_addr", m_addr, 32'd0);
        check("reset rdata", i_rdata | d_rdata, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post-reset idle", {31'd0, m_req}, 32'd0);
        $display("[TB] txn reset        outputs checked");

        for (int k = 0; k < 7; k++) run_txn(vecs[k]);

        // Simultaneous requests: data first, instruction two cycles later.
        mem_delay = 1; mem_rdata = 32'h0000_00AA;
        cd = -1; ci = -1;
        i_req = 1'b1; i_addr = 32'h300;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h310;
        for (int c = 1; c <= 20 && (cd < 0 || ci < 0); c++) begin
            @(posedge clk); #1;
            if (d_ready) begin cd = c; d_req = 1'b0; end
            if (i_ready) begin ci = c; i_req = 1'b0; end
        end
        d_req = 1'b0; i_req = 1'b0;
        check("simul d_ready_cycle", 32'(cd), 32'd2);
        check("simul i_ready_cycle", 32'(ci), 32'd4);
        $display("[TB] txn simultaneous d_ready@%0d i_ready@%0d", cd, ci);
        @(posedge clk); #1;

        // Fairness: 4 data grants, 1 instruction grant, then data again.
        exp_ev = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        ev     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        nev = 0;
        i_req = 1'b1; i_addr = 32'h400;
        d_req = 1'b1; d_addr = 32'h500;
        for (int c = 0; c < 60 && nev < 6; c++) begin
            @(posedge clk); #1;
            if (d_ready) begin ev[nev] = 1'b1; nev++; end
            else if (i_ready) begin ev[nev] = 1'b0; nev++; i_req = 1'b0; end
        end
        d_req = 1'b0; i_req = 1'b0;
        check("fair events", 32'(nev), 32'd6);
        for (int k = 0; k < 6; k++)
            check($sformatf("fair grant%0d is_data", k), 32'(ev[k]), 32'(exp_ev[k]));
        $display("[TB] txn fairness     grants(D=1)=%0b%0b%0b%0b%0b%0b",
                 ev[0], ev[1], ev[2], ev[3], ev[4], ev[5]);
        repeat (2) @(posedge clk);
        #1;

        // m_ack while idle must be ignored.
        stray = 1'b0;
        spurious_ack = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            if (i_ready || d_ready || err || m_req) stray = 1'b1;
        end
        spurious_ack = 1'b0;
        @(posedge clk); #1;
        check("idle ack ignored", 32'(stray), 32'd0);
        $display("[TB] txn idle_ack     stray=%0b", stray);

        // Reset two cycles into BUSY_D.
        mem_delay = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
        cd = 0;
        while (!m_req && cd < 10) begin
            @(posedge clk); #1;
            cd++;
        end
        check("rst_mid granted", 32'(m_req), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid outputs", {29'd0, m_req, d_ready, err}, 32'd0);
        check("rst_mid m_addr", m_addr, 32'd0);
        d_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        $display("[TB] txn reset_mid    m_req=%0b d_ready=%0b err=%0b", m_req, d_ready, err);
        v = mk("after_rst", 0, 0, 32'h700, 32'h0, 2, 32'h3C1D_0040, 32'h3C1D_0040, 0, 2);
        run_txn(v);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
